// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding, default geometry and line type for the store-side dcache.
package dcache_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_LINES = 16;
  localparam int DEF_LINE_WORDS = 4;
  localparam int BYTE_OFF_W = $clog2(DEF_DATA_W / 8);
  localparam int WORD_OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int INDEX_W = $clog2(DEF_NUM_LINES);
  localparam int TAG_W = DEF_ADDR_W - INDEX_W - WORD_OFF_W - BYTE_OFF_W;
  typedef enum logic [1:0] {IDLE, ACK, WRITEBACK, REFILL} state_t;
  typedef logic [DEF_LINE_WORDS-1:0][DEF_DATA_W-1:0] line_t;
endpackage

// File: rtl/dcache_line_array.sv
// dcache_line_array: direct-mapped tag/valid/dirty/data store with one read port,
// a byte-masked word write, a full-line refill write and a dirty clear.
module dcache_line_array #(
  parameter int DATA_W = 32,
  parameter int NUM_LINES = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(NUM_LINES)-1:0] idx,
  input  logic [$clog2(LINE_WORDS)-1:0] word,
  output logic [TAG_W-1:0]             rd_tag,
  output logic                         rd_valid,
  output logic                         rd_dirty,
  output logic [DATA_W*LINE_WORDS-1:0] rd_line,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [DATA_W/8-1:0]          wr_be,
  input  logic                         fill_en,
  input  logic [TAG_W-1:0]             fill_tag,
  input  logic [DATA_W*LINE_WORDS-1:0] fill_line,
  input  logic                         clr_dirty
);
  logic [TAG_W-1:0] tags [NUM_LINES];
  logic [DATA_W*LINE_WORDS-1:0] data [NUM_LINES];
  logic [NUM_LINES-1:0] valid, dirty;
  assign rd_tag = tags[idx];
  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_line = data[idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (wr_en) dirty[idx] <= 1'b1;
    else if (clr_dirty) dirty[idx] <= 1'b0;
  // tag and data storage carry no reset; valid gates every use
  always_ff @(posedge clk)
    if (fill_en) begin
      tags[idx] <= fill_tag;
      data[idx] <= fill_line;
    end else if (wr_en)
      for (int b = 0; b < DATA_W / 8; b++)
        if (wr_be[b]) data[idx][int'(word) * DATA_W + b * 8 +: 8] <= wr_data[b * 8 +: 8];
endmodule

// File: rtl/stb_dcache_write_responder.sv
// stb_dcache_write_responder: accepts buffered stores into a write-back, write-allocate
// direct-mapped line array, fetching/evicting lines over a line-wide memory port.
module stb_dcache_write_responder
  import dcache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stb2dcache_req,
  input  logic                         stb2dcache_w_en,
  input  logic [ADDR_W-1:0]            stb2dcache_addr,
  input  logic [DATA_W-1:0]            stb2dcache_wdata,
  input  logic [DATA_W/8-1:0]          stb2dcache_sel_byte,
  output logic                         dcache2stb_ack,
  output logic                         dcache_busy,
  output logic                         dcache2mem_req,
  output logic                         dcache2mem_wr,
  output logic [ADDR_W-1:0]            dcache2mem_addr,
  output logic [DATA_W*LINE_WORDS-1:0] dcache2mem_wdata,
  input  logic                         mem2dcache_ack,
  input  logic [DATA_W*LINE_WORDS-1:0] mem2dcache_rdata
);
  localparam int BO_W = $clog2(DATA_W / 8);
  localparam int WO_W = $clog2(LINE_WORDS);
  localparam int IX_W = $clog2(NUM_LINES);
  localparam int OFF_W = BO_W + WO_W;
  localparam int TG_W = ADDR_W - OFF_W - IX_W;
  state_t state;
  logic [TG_W-1:0] tag, rd_tag;
  logic [IX_W-1:0] idx;
  logic [WO_W-1:0] word;
  logic [DATA_W*LINE_WORDS-1:0] rd_line;
  logic rd_valid, rd_dirty, req, hit, victim, unused_bo;
  assign {tag, idx, word} = stb2dcache_addr[ADDR_W-1:BO_W];
  assign unused_bo = ^stb2dcache_addr[BO_W-1:0];
  assign req = stb2dcache_req && stb2dcache_w_en;
  assign hit = rd_valid && rd_tag == tag;
  assign victim = rd_valid && rd_dirty;
  dcache_line_array #(
    .DATA_W(DATA_W), .NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS), .TAG_W(TG_W)
  ) u_lines (
    .clk(clk),
    .rst_n(rst_n),
    .idx(idx),
    .word(word),
    .rd_tag(rd_tag),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_line(rd_line),
    .wr_en(state == IDLE && req && hit),
    .wr_data(stb2dcache_wdata),
    .wr_be(stb2dcache_sel_byte),
    .fill_en(state == REFILL && mem2dcache_ack),
    .fill_tag(tag),
    .fill_line(mem2dcache_rdata),
    .clr_dirty(state == WRITEBACK && mem2dcache_ack)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dcache2stb_ack <= 1'b0;
      dcache_busy <= 1'b0;
      dcache2mem_req <= 1'b0;
      dcache2mem_wr <= 1'b0;
      dcache2mem_addr <= '0;
      dcache2mem_wdata <= '0;
    end else
      case (state)
        IDLE:
          if (req) begin
            dcache_busy <= 1'b1;
            if (hit) begin
              state <= ACK;
              dcache2stb_ack <= 1'b1;
            end else begin
              state <= victim ? WRITEBACK : REFILL;
              dcache2mem_req <= 1'b1;
              dcache2mem_wr <= victim;
              dcache2mem_addr <= {victim ? rd_tag : tag, idx, {OFF_W{1'b0}}};
              dcache2mem_wdata <= rd_line;
            end
          end
        ACK: begin
          state <= IDLE;
          dcache2stb_ack <= 1'b0;
          dcache_busy <= 1'b0;
        end
        // refill request follows the writeback with no gap
        WRITEBACK:
          if (mem2dcache_ack) begin
            state <= REFILL;
            dcache2mem_wr <= 1'b0;
            dcache2mem_addr <= {tag, idx, {OFF_W{1'b0}}};
          end
        REFILL:
          if (mem2dcache_ack) begin
            state <= IDLE;
            dcache2mem_req <= 1'b0;
            dcache_busy <= 1'b0;
          end
      endcase
endmodule
